memory_read_arbiter: RTL and testbench

- Shares one memory read-address/read-data port pair between N requesters, in the codebase's stb/rdy handshake style.
- Arbitrates read addresses round-robin and forwards the winner to the memory.
- Records each issued grant in a small tag FIFO and routes each returning read datum to the requester that issued it, in order.
- Sits between the compute units and the memory's ar/r channels; the write channels are not touched.

---
 rtl/memory_read_arbiter.sv | 176 +++++++++++++++++
 tb/tb_memory_read_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_arbiter.sv
// Round-robin read-address arbiter for N requesters sharing one memory ar/r port pair.
// A tag FIFO of granted requester indices steers in-order read data back to its issuer.
module memory_read_arbiter #(
   parameter int unsigned N           = 2,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned OUTSTANDING = 2,
   localparam int unsigned AW         = $clog2(DEPTH),
   localparam int unsigned TW         = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned PW         = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1,
   localparam int unsigned CW         = $clog2(OUTSTANDING + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [N-1:0]      s_ar_stb_i,
   input  logic [N*AW-1:0]   s_ar_dat_i,
   output logic [N-1:0]      s_ar_rdy_o,
   output logic [N-1:0]      s_r_stb_o,
   output logic [WIDTH-1:0]  s_r_dat_o,
   input  logic [N-1:0]      s_r_rdy_i,
   output logic              m_ar_stb_o,
   output logic [AW-1:0]     m_ar_dat_o,
   input  logic              m_ar_rdy_i,
   input  logic              m_r_stb_i,
   input  logic [WIDTH-1:0]  m_r_dat_i,
   output logic              m_r_rdy_o,
   output logic              err_o
);

   logic [TW-1:0] ptr_q, ptr_d;
   logic [TW-1:0] gnt_q, gnt_d;
   logic          lock_q, lock_d;
   logic          err_q, err_d;

   logic [TW-1:0] tag_q [OUTSTANDING];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [TW-1:0] pick;
   logic [TW-1:0] sel;
   logic [TW-1:0] head;
   logic          found;
   logic          fifo_full;
   logic          fifo_empty;
   logic          ar_hs;
   logic          push;
   logic          pop;
   logic          head_rdy;
   int            cand;

   assign fifo_full  = (count_q == CW'(OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign head       = tag_q[rptr_q];

   // First strobing requester at or after ptr, wrapping modulo N.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < int'(N); k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= int'(N)) begin
            cand = cand - int'(N);
         end
         if (!found && s_ar_stb_i[TW'(cand)]) begin
            pick  = TW'(cand);
            found = 1'b1;
         end
      end
   end

   assign sel = lock_q ? gnt_q : pick;

   // Outputs are gated by reset so they drop the instant reset asserts.
   assign m_ar_stb_o = rst_ni & (|s_ar_stb_i) & ~fifo_full;
   assign ar_hs      = m_ar_stb_o & m_ar_rdy_i;
   assign push       = ar_hs;

   always_comb begin
      m_ar_dat_o = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (sel == TW'(i)) begin
            m_ar_dat_o = s_ar_dat_i[i*AW +: AW];
         end
      end
   end

   always_comb begin
      s_ar_rdy_o = '0;
      for (int i = 0; i < int'(N); i++) begin
         s_ar_rdy_o[i] = m_ar_stb_o & m_ar_rdy_i & (sel == TW'(i));
      end
   end

   always_comb begin
      head_rdy  = 1'b0;
      s_r_stb_o = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (head == TW'(i)) begin
            head_rdy     = s_r_rdy_i[i];
            s_r_stb_o[i] = m_r_stb_i & ~fifo_empty;
         end
      end
   end

   assign s_r_dat_o = m_r_dat_i;
   // An empty FIFO drains anything the memory sends so it cannot wedge.
   assign m_r_rdy_o = fifo_empty | head_rdy;
   assign pop       = m_r_stb_i & m_r_rdy_o & ~fifo_empty;
   assign err_o     = err_q;

   always_comb begin
      lock_d = lock_q;
      gnt_d  = gnt_q;
      ptr_d  = ptr_q;
      if (ar_hs) begin
         lock_d = 1'b0;
         ptr_d  = (int'(sel) == int'(N) - 1) ? '0 : sel + TW'(1);
      end else if (m_ar_stb_o) begin
         lock_d = 1'b1;
         gnt_d  = sel;
      end
   end

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      err_d = err_q;
      if (m_r_stb_i && fifo_empty) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q  <= '0;
         gnt_q  <= '0;
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         gnt_q  <= gnt_d;
         lock_q <= lock_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(OUTSTANDING); i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push) begin
            tag_q[wptr_q] <= sel;
         end
      end
   end

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter with a behavioural one-cycle-latency memory
// and a scoreboard of expected (requester, data) responses.
module tb_memory_read_arbiter;

   localparam int unsigned N    = 2;
   localparam int unsigned W    = 16;
   localparam int unsigned AW   = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  s_ar_stb;
   logic [N*AW-1:0] s_ar_dat;
   logic [N-1:0]  s_ar_rdy;
   logic [N-1:0]  s_r_stb;
   logic [W-1:0]  s_r_dat;
   logic [N-1:0]  s_r_rdy;
   logic          m_ar_stb;
   logic [AW-1:0] m_ar_dat;
   logic          m_ar_rdy;
   logic          m_r_stb;
   logic [W-1:0]  m_r_dat;
   logic          m_r_rdy;
   logic          err;

   logic [AW-1:0] req_addr [N];
   logic [W-1:0]  mem [256];
   logic [W-1:0]  mem_q [$];
   logic          orphan;
   int            gnt_log [$];

   typedef struct {
      int unsigned   dest;
      logic [W-1:0]  data;
   } exp_t;
   exp_t sb [$];

   int checks;
   int failures;

   assign s_ar_dat = {req_addr[1], req_addr[0]};

   memory_read_arbiter #(
      .N(N), .WIDTH(W), .DEPTH(256), .OUTSTANDING(2)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .s_ar_stb_i (s_ar_stb),
      .s_ar_dat_i (s_ar_dat),
      .s_ar_rdy_o (s_ar_rdy),
      .s_r_stb_o  (s_r_stb),
      .s_r_dat_o  (s_r_dat),
      .s_r_rdy_i  (s_r_rdy),
      .m_ar_stb_o (m_ar_stb),
      .m_ar_dat_o (m_ar_dat),
      .m_ar_rdy_i (m_ar_rdy),
      .m_r_stb_i  (m_r_stb),
      .m_r_dat_i  (m_r_dat),
      .m_r_rdy_o  (m_r_rdy),
      .err_o      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Called at the negedge: observe handshakes, then advance past the posedge and update memory.
   task automatic step();
      logic          acc;
      logic [AW-1:0] acc_addr;
      logic          hs_r;
      exp_t          e;
      acc      = 1'b0;
      acc_addr = '0;
      hs_r     = m_r_stb && m_r_rdy;
      if (m_ar_stb) chk("ar_rdy_onehot", ($countones(s_ar_rdy) <= 1), 1);
      for (int i = 0; i < int'(N); i++) begin
         if (s_ar_stb[i] && s_ar_rdy[i] && m_ar_stb && m_ar_rdy) begin
            gnt_log.push_back(i);
            sb.push_back('{dest: i, data: mem[req_addr[i]]});
            chk("ar_addr", m_ar_dat, req_addr[i]);
            acc      = 1'b1;
            acc_addr = req_addr[i];
         end
      end
      if (m_r_stb) chk("r_stb_onehot", ($countones(s_r_stb) <= 1), 1);
      for (int i = 0; i < int'(N); i++) begin
         if (s_r_stb[i] && s_r_rdy[i]) begin
            chk("r_sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("r_dest", i, e.dest);
               chk("r_data", s_r_dat, e.data);
            end
         end
      end
      @(posedge clk);
      #1;
      if (hs_r && mem_q.size() > 0) void'(mem_q.pop_front());
      if (acc) mem_q.push_back(mem[acc_addr]);
      if (mem_q.size() > 0) begin
         m_r_stb = 1'b1;
         m_r_dat = mem_q[0];
      end else begin
         m_r_stb = orphan;
         m_r_dat = 16'hDEAD;
      end
   endtask

   task automatic cyc();
      settle();
      step();
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && (sb.size() > 0 || mem_q.size() > 0); k++) cyc();
      chk("drain_sb_empty", sb.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_m_ar_stb"}, m_ar_stb, 0);
      chk({tag, "_s_ar_rdy"}, s_ar_rdy, 0);
      chk({tag, "_s_r_stb"}, s_r_stb, 0);
      chk({tag, "_m_r_rdy"}, m_r_rdy, 1);
      chk({tag, "_err"}, err, 0);
   endtask

   // Entered just after a posedge; memory is reset together with the arbiter.
   task automatic do_reset();
      s_ar_stb = '0;
      rst_n    = 1'b0;
      mem_q.delete();
      sb.delete();
      gnt_log.delete();
      orphan   = 1'b0;
      m_r_stb  = 1'b0;
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int a = 0; a < 256; a++) mem[a] = 16'(a * 257) ^ 16'h3C5A;
      mem[8'h12] = 16'hBEEF;
      rst_n       = 1'b0;
      s_ar_stb    = '0;
      req_addr[0] = '0;
      req_addr[1] = '0;
      s_r_rdy     = '1;
      m_ar_rdy    = 1'b1;
      m_r_stb     = 1'b0;
      m_r_dat     = '0;
      orphan      = 1'b0;
      #1;
      check_reset_outputs("por");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single requester
      req_addr[0] = 8'h12;
      s_ar_stb    = 2'b01;
      settle();
      chk("single_ar_rdy", s_ar_rdy, 2'b01);
      chk("single_m_ar_dat", m_ar_dat, 8'h12);
      step();
      s_ar_stb = 2'b00;
      settle();
      chk("single_r_stb", s_r_stb, 2'b01);
      chk("single_r_dat", s_r_dat, 16'hBEEF);
      step();
      settle();
      chk("single_r_stb_idle", s_r_stb, 2'b00);
      step();
      drain();

      // Round robin with both requesters strobing continuously
      do_reset();
      req_addr[0] = 8'h01;
      req_addr[1] = 8'h02;
      s_ar_stb    = 2'b11;
      repeat (4) cyc();
      s_ar_stb = 2'b00;
      drain();
      chk("rr_count", gnt_log.size(), 4);
      if (gnt_log.size() == 4) begin
         for (int k = 0; k < 4; k++) chk("rr_order", gnt_log[k], k % 2);
      end

      // Lock holds the selection while the memory stalls
      do_reset();
      m_ar_rdy    = 1'b0;
      req_addr[0] = 8'h44;
      req_addr[1] = 8'h33;
      s_ar_stb    = 2'b10;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("lock_m_ar_stb", m_ar_stb, 1);
         chk("lock_m_ar_dat", m_ar_dat, 8'h33);
         step();
      end
      s_ar_stb = 2'b11;
      settle();
      chk("lock_hold_dat", m_ar_dat, 8'h33);
      chk("lock_hold_rdy", s_ar_rdy, 2'b00);
      step();
      m_ar_rdy = 1'b1;
      settle();
      chk("lock_release_rdy", s_ar_rdy, 2'b10);
      chk("lock_release_dat", m_ar_dat, 8'h33);
      step();
      s_ar_stb = 2'b01;
      settle();
      chk("lock_next_rdy", s_ar_rdy, 2'b01);
      chk("lock_next_dat", m_ar_dat, 8'h44);
      step();
      s_ar_stb = 2'b00;
      drain();
      chk("lock_count", gnt_log.size(), 2);
      if (gnt_log.size() == 2) begin
         chk("lock_first", gnt_log[0], 1);
         chk("lock_second", gnt_log[1], 0);
      end

      // Tag FIFO fills while the head requester stalls
      do_reset();
      s_r_rdy     = 2'b00;
      req_addr[0] = 8'h40;
      s_ar_stb    = 2'b01;
      cyc();
      cyc();
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("full_m_ar_stb", m_ar_stb, 0);
         chk("full_s_ar_rdy", s_ar_rdy, 2'b00);
         chk("full_m_r_rdy", m_r_rdy, 0);
         step();
      end
      chk("full_accepted", gnt_log.size(), 2);
      s_r_rdy = 2'b01;
      settle();
      chk("full_pop_r_stb", s_r_stb, 2'b01);
      chk("full_pop_m_r_rdy", m_r_rdy, 1);
      chk("full_pop_m_ar_stb", m_ar_stb, 0);
      step();
      s_r_rdy = 2'b00;
      settle();
      chk("full_regrant_stb", m_ar_stb, 1);
      chk("full_regrant_rdy", s_ar_rdy, 2'b01);
      step();
      settle();
      chk("full_again_stb", m_ar_stb, 0);
      step();
      chk("full_total", gnt_log.size(), 3);
      s_ar_stb = 2'b00;
      s_r_rdy  = 2'b11;
      drain();

      // Asynchronous reset with two reads in flight
      do_reset();
      s_r_rdy     = 2'b00;
      req_addr[0] = 8'h50;
      s_ar_stb    = 2'b01;
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_s_r_stb", s_r_stb, 2'b00);
      chk("areset_m_ar_stb", m_ar_stb, 0);
      chk("areset_s_ar_rdy", s_ar_rdy, 2'b00);
      chk("areset_m_r_rdy", m_r_rdy, 1);
      s_ar_stb = 2'b00;
      mem_q.delete();
      sb.delete();
      gnt_log.delete();
      m_r_stb  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      req_addr[0] = 8'h05;
      req_addr[1] = 8'h06;
      s_r_rdy     = 2'b11;
      s_ar_stb    = 2'b11;
      settle();
      chk("areset_ptr0_rdy", s_ar_rdy, 2'b01);
      chk("areset_ptr0_dat", m_ar_dat, 8'h05);
      step();
      s_ar_stb = 2'b00;
      drain();
      chk("areset_count", gnt_log.size(), 1);

      // Orphan response with nothing outstanding
      orphan  = 1'b1;
      m_r_stb = 1'b1;
      m_r_dat = 16'hDEAD;
      settle();
      chk("orphan_m_r_rdy", m_r_rdy, 1);
      chk("orphan_s_r_stb", s_r_stb, 2'b00);
      chk("orphan_err_pre", err, 0);
      step();
      orphan  = 1'b0;
      m_r_stb = 1'b0;
      settle();
      chk("orphan_err_set", err, 1);
      step();
      repeat (3) cyc();
      settle();
      chk("orphan_err_sticky", err, 1);
      step();
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
